// File: rtl/seal_log_fifo_pkg.sv
// Shared seal definitions: the 56-bit record layout, the log_status bit map
// and the drop-counter ceiling used by the seal stage and its log FIFO.
package seal_log_fifo_pkg;

  localparam int MONO_W = 32;
  localparam int SESS_W = 8;
  localparam int CRC_W  = 16;
  localparam int REC_W  = MONO_W + SESS_W + CRC_W;

  // Record fields, MSB first: mono[55:24], session[23:16], crc[15:0]
  localparam int REC_CRC_LSB  = 0;
  localparam int REC_SESS_LSB = CRC_W;
  localparam int REC_MONO_LSB = CRC_W + SESS_W;

  typedef struct packed {
    logic [MONO_W-1:0] mono;
    logic [SESS_W-1:0] session;
    logic [CRC_W-1:0]  crc;
  } seal_rec_t;

  // log_status map: drop_cnt[31:24], count[12:8], phase[3], overflow[2], full[1], empty[0]
  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_PHASE    = 3;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_DROP_LSB = 24;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [31:0] pack_status(
    input logic [7:0] drop_cnt,
    input logic [4:0] count,
    input logic       phase,
    input logic       overflow,
    input logic       full,
    input logic       empty
  );
    logic [31:0] s;
    s = '0;
    s[ST_DROP_LSB +: 8] = drop_cnt;
    s[ST_CNT_LSB +: 5]  = count;
    s[ST_PHASE]         = phase;
    s[ST_OVF]           = overflow;
    s[ST_FULL]          = full;
    s[ST_EMPTY]         = empty;
    return s;
  endfunction

  function automatic logic [31:0] rec_word(input seal_rec_t rec, input logic phase);
    return phase ? {rec.session, 8'h00, rec.crc} : rec.mono;
  endfunction

endpackage

// File: rtl/seal_log_fifo.sv
// Circular log of sealed commit records, read out by the host as two
// 32-bit words per record; overflowing commits are dropped and counted.
module seal_log_fifo
  import seal_log_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seal_done,
  input  logic [MONO_W-1:0] seal_mono,
  input  logic [SESS_W-1:0] seal_session,
  input  logic [CRC_W-1:0]  seal_crc,
  input  logic              log_rd,
  input  logic              log_clr,
  output logic [31:0]       log_data,
  output logic [31:0]       log_status
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  seal_rec_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_phase;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic      w_empty;
  logic      w_full;
  logic      w_rd_ok;
  logic      w_pop;
  logic      w_push;
  logic      w_drop;
  seal_rec_t w_head;
  seal_rec_t w_new;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_rd_ok = log_rd && !w_empty;
  assign w_pop   = w_rd_ok && r_phase;
  // A same-cycle pop frees the slot, so a full buffer still accepts the push.
  assign w_push  = seal_done && (!w_full || w_pop);
  assign w_drop  = seal_done && !w_push;

  assign w_new = '{mono: seal_mono, session: seal_session, crc: seal_crc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_phase    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (log_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_phase    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_rd_ok) r_phase <= ~r_phase;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Storage carries no reset; empty gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push && !log_clr) r_mem[r_wr_ptr] <= w_new;
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign log_data = w_empty ? 32'h0 : rec_word(w_head, r_phase);

  assign log_status = pack_status(r_drop_cnt, 5'(r_count), r_phase, r_overflow,
                                  w_full, w_empty);

endmodule

// File: tb/tb_seal_log_fifo.sv
// Directed bench for seal_log_fifo: a queue-based model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_seal_log_fifo;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        seal_done;
  logic [31:0] seal_mono;
  logic [7:0]  seal_session;
  logic [15:0] seal_crc;
  logic        log_rd;
  logic        log_clr;
  logic [31:0] log_data;
  logic [31:0] log_status;

  int checks = 0;
  int errors = 0;

  seal_log_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seal_done    (seal_done),
    .seal_mono    (seal_mono),
    .seal_session (seal_session),
    .seal_crc     (seal_crc),
    .log_rd       (log_rd),
    .log_clr      (log_clr),
    .log_data     (log_data),
    .log_status   (log_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: records in push order, read phase, sticky overflow, drop counter.
  logic [55:0] m_q[$];
  logic        m_phase;
  logic        m_ovf;
  int          m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_phase = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else if (log_clr) begin
      m_q.delete();
      m_phase = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else begin
      if (log_rd && m_q.size() > 0) begin
        if (m_phase) void'(m_q.pop_front());
        m_phase = ~m_phase;
      end
      if (seal_done) begin
        if (m_q.size() < DEPTH) m_q.push_back({seal_mono, seal_session, seal_crc});
        else begin
          m_ovf  = 1'b1;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end
    end
  end

  function automatic logic [31:0] exp_data();
    logic [55:0] h;
    if (m_q.size() == 0) return 32'h0;
    h = m_q[0];
    return m_phase ? {h[23:16], 8'h00, h[15:0]} : h[55:24];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = m_q.size();
    s = '0;
    s[31:24] = 8'(m_drop);
    s[12:8]  = 5'(n);
    s[3]     = m_phase;
    s[2]     = m_ovf;
    s[1]     = (n == DEPTH);
    s[0]     = (n == 0);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_data", log_data, 32'h0);
      chk("rst_status", log_status, 32'h0000_0001);
    end else begin
      chk("model_data", log_data, exp_data());
      chk("model_status", log_status, exp_status());
    end
  end

  // One clock with the given strobes; returns at the following negedge.
  task automatic cyc(input logic done, input logic [31:0] mono, input logic [7:0] sess,
                     input logic [15:0] crc, input logic rd, input logic clr);
    seal_done = done; seal_mono = mono; seal_session = sess; seal_crc = crc;
    log_rd = rd; log_clr = clr;
    @(negedge clk);
    seal_done = 1'b0; log_rd = 1'b0; log_clr = 1'b0;
    $display("cyc t=%0t done=%0b mono=%08h rd=%0b clr=%0b -> data=%08h status=%08h",
             $time, done, mono, rd, clr, log_data, log_status);
  endtask

  task automatic push(input logic [31:0] mono);
    cyc(1'b1, mono, mono[7:0] ^ 8'hA5, mono[15:0] ^ 16'h1234, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 32'h0, 8'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; seal_done = 1'b0; seal_mono = '0; seal_session = '0; seal_crc = '0;
    log_rd = 1'b0; log_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("lit_reset_status", log_status, 32'h0000_0001);
    rst_n = 1'b1;
    @(negedge clk);

    // Single record round trip
    cyc(1'b1, 32'd5, 8'h3C, 16'hBEEF, 1'b0, 1'b0);
    chk("lit_word0", log_data, 32'd5);
    rd();
    chk("lit_word1", log_data, 32'h3C00_BEEF);
    rd();
    chk("lit_empty_data", log_data, 32'h0);
    chk("lit_empty_status", log_status, 32'h0000_0001);
    rd();  // read while empty changes nothing
    chk("lit_rd_empty", log_status, 32'h0000_0001);

    // Overflow by one, then drain in order
    for (int i = 1; i <= 5; i++) push(32'(i));
    chk("lit_ovf_status", log_status, 32'h0100_0406);
    for (int i = 1; i <= 4; i++) begin
      chk("lit_order_w0", log_data, 32'(i));
      rd();
      rd();
    end
    chk("lit_drained", log_status, 32'h0100_0005);
    clr();

    // Pop and push together while full
    for (int i = 10; i <= 13; i++) push(32'(i));
    rd();
    cyc(1'b1, 32'd14, 8'h01, 16'h0002, 1'b1, 1'b0);
    chk("lit_swap_status", log_status, 32'h0000_0402);
    for (int i = 11; i <= 14; i++) begin
      chk("lit_swap_order", log_data, 32'(i));
      rd();
      rd();
    end

    // Saturating drop counter, then flush
    for (int i = 0; i < 4; i++) push(32'(100 + i));
    for (int i = 0; i < 300; i++) push(32'(200 + i));
    chk("lit_drop_sat", log_status, 32'hFF00_0406);
    clr();
    chk("lit_clr", log_status, 32'h0000_0001);

    // Reset in the middle of a record readout
    push(32'h21); push(32'h22);
    rd();
    #2 rst_n = 1'b0;
    #1 chk("lit_async_rst_data", log_data, 32'h0);
    chk("lit_async_rst_status", log_status, 32'h0000_0001);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_after_rst", log_status, 32'h0000_0001);
    push(32'h77);
    chk("lit_post_rst_push", log_data, 32'h77);
    rd();
    chk("lit_post_rst_w1", log_data, {8'h77 ^ 8'hA5, 8'h00, 16'h0077 ^ 16'h1234});
    rd();

    // Mixed traffic: concurrent push/pop at partial fill, clear colliding with commits
    for (int i = 0; i < 200; i++) begin
      cyc((i % 3) != 0, 32'(1000 + i), 8'(i), 16'(i * 7), (i % 2) == 0 || (i % 5) == 1,
          (i % 61) == 60);
    end
    clr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
